// File: rtl/configuration_register_bank_pkg.sv
// Common constants and helpers for the configuration register bank.
package configuration_register_bank_pkg;
`include "configuration_bus_defs.vh"

   // Expands per-byte enables into a per-bit write mask on the bus.
   function automatic logic [BUS_WIDTH-1:0] expand_byte_mask(
      input logic [BYTE_COUNT-1:0] byte_select
   );
      logic [BUS_WIDTH-1:0] mask;
      mask = {BUS_WIDTH{1'b0}};
      for (int k = 0; k < BYTE_COUNT; k++) begin
         mask[8*k +: 8] = {8{byte_select[k]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/configuration_bus_defs.vh
// Shared geometry of the peripheral configuration bus.
`ifndef CONFIGURATION_BUS_DEFS_VH
`define CONFIGURATION_BUS_DEFS_VH
localparam int REGISTER_STRIDE = 4;
localparam int BUS_WIDTH       = 32;
localparam int BYTE_COUNT      = 4;
`endif

// File: rtl/configuration_register_cell.sv
// One configuration register: byte-masked write, reset value and a
// registered one-cycle write strobe.
module configuration_register_cell
   import configuration_register_bank_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 write_enable,
   input  logic [BUS_WIDTH-1:0] write_data,
   input  logic [BUS_WIDTH-1:0] write_mask,
   output logic [WIDTH-1:0]     value,
   output logic                 written
);

   logic [WIDTH-1:0] next_value_s;

   // Merge enabled bytes of the bus data over the held value; bits above WIDTH are dropped.
   always_comb begin
      next_value_s = (value & ~write_mask[WIDTH-1:0])
                   | (write_data[WIDTH-1:0] & write_mask[WIDTH-1:0]);
   end

   // Register storage and write strobe; reset overrides any same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         value   <= RESET_VALUE;
         written <= 1'b0;
      end else begin
         if (write_enable) begin
            value <= next_value_s;
         end else begin
            value <= value;
         end
         written <= write_enable;
      end
   end

endmodule

// File: rtl/configuration_register_bank.sv
// Memory-mapped bank of configuration registers plus a sticky
// write-1-to-clear status register with an interrupt output.
module configuration_register_bank
   import configuration_register_bank_pkg::*;
#(
   parameter logic [31:0]                      BASE_ADDRESS   = 32'h0,
   parameter int                               REGISTER_COUNT = 4,
   parameter int                               WIDTH          = 32,
   parameter logic [REGISTER_COUNT*WIDTH-1:0]  RESET_VALUE    = '0,
   parameter int                               STATUS_WIDTH   = 8,
   // A zero-width status register still needs a one-bit port.
   localparam int                              SW = (STATUS_WIDTH > 0) ? STATUS_WIDTH : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              we,
   input  logic                              oe,
   input  logic [31:0]                       interfaceAddress,
   input  logic [3:0]                        byteSelect,
   inout  wire  [31:0]                       interfaceData,
   input  logic [SW-1:0]                     statusEvent,
   output logic [REGISTER_COUNT*WIDTH-1:0]   currentValues,
   output logic [REGISTER_COUNT-1:0]         registerWritten,
   output logic [SW-1:0]                     statusValue,
   output logic                              irq
);

   logic [31:0]          offset_s;
   logic [31:0]          word_index_s;
   logic                 aligned_s;
   logic                 config_select_s;
   logic                 status_select_s;
   logic                 bus_write_s;
   logic                 bus_read_s;
   logic [3:0]           register_index_s;
   logic [BUS_WIDTH-1:0] write_mask_s;
   logic [BUS_WIDTH-1:0] read_data_s;
   logic [SW-1:0]        status_r;
   logic [WIDTH-1:0]     register_value_s [REGISTER_COUNT];

   // Address decode: addresses below BASE_ADDRESS wrap to huge offsets and fall out of range.
   always_comb begin
      offset_s         = interfaceAddress - BASE_ADDRESS;
      word_index_s     = offset_s / 32'(REGISTER_STRIDE);
      aligned_s        = ((offset_s % 32'(REGISTER_STRIDE)) == 32'd0);
      register_index_s = word_index_s[3:0];
      if (aligned_s && (word_index_s < 32'(REGISTER_COUNT))) begin
         config_select_s = 1'b1;
      end else begin
         config_select_s = 1'b0;
      end
      if ((STATUS_WIDTH > 0) && aligned_s && (word_index_s == 32'(REGISTER_COUNT))) begin
         status_select_s = 1'b1;
      end else begin
         status_select_s = 1'b0;
      end
      bus_write_s  = we && !oe;
      bus_read_s   = oe && !we;
      write_mask_s = expand_byte_mask(byteSelect);
   end

   genvar i;
   generate
      for (i = 0; i < REGISTER_COUNT; i++) begin : g_cell
         configuration_register_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE[i*WIDTH +: WIDTH])
         ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .write_enable (config_select_s && bus_write_s && (register_index_s == 4'(i))),
            .write_data   (interfaceData),
            .write_mask   (write_mask_s),
            .value        (register_value_s[i]),
            .written      (registerWritten[i])
         );
         assign currentValues[i*WIDTH +: WIDTH] = register_value_s[i];
      end

      if (STATUS_WIDTH > 0) begin : g_status
         logic [SW-1:0] clear_s;

         // W1C clear bits: only enabled bytes of a status write take effect.
         always_comb begin
            if (status_select_s && bus_write_s) begin
               clear_s = interfaceData[SW-1:0] & write_mask_s[SW-1:0];
            end else begin
               clear_s = {SW{1'b0}};
            end
         end

         // Sticky status: events set, W1C clears, set wins over clear, reset wins over both.
         always_ff @(posedge clk) begin
            if (rst) begin
               status_r <= {SW{1'b0}};
            end else begin
               status_r <= (status_r & ~clear_s) | statusEvent;
            end
         end
      end else begin : g_no_status
         assign status_r = {SW{1'b0}};
      end
   endgenerate

   assign statusValue = status_r;
   assign irq         = |status_r;

   // Read mux: selected register or status, zero-extended to the bus width.
   always_comb begin
      read_data_s = {BUS_WIDTH{1'b0}};
      if (config_select_s) begin
         read_data_s = BUS_WIDTH'(register_value_s[register_index_s]);
      end else if (status_select_s) begin
         read_data_s = BUS_WIDTH'(status_r);
      end else begin
         read_data_s = {BUS_WIDTH{1'b0}};
      end
   end

   assign interfaceData = (bus_read_s && (config_select_s || status_select_s))
                          ? read_data_s : 32'bz;

endmodule

// File: tb/tb_configuration_register_bank.sv
// Directed self-checking bench for configuration_register_bank.
// Bank A: two 32-bit registers at 0x100 with an 8-bit status register.
// Bank B: one 12-bit register at 0x0 without a status register.
// Both buses carry pull-ups, so an undriven bus reads as all ones.
module tb_configuration_register_bank;

   logic        clk;
   logic        rst;

   logic        we_a, oe_a, drive_a;
   logic [31:0] addr_a, data_a;
   logic [3:0]  be_a;
   logic [7:0]  event_a;
   wire  [31:0] bus_a;
   logic [63:0] values_a;
   logic [1:0]  written_a;
   logic [7:0]  status_a;
   logic        irq_a;

   logic        we_b, oe_b, drive_b;
   logic [31:0] addr_b, data_b;
   logic [3:0]  be_b;
   wire  [31:0] bus_b;
   logic [11:0] values_b;
   logic [0:0]  written_b;
   logic [0:0]  status_b;
   logic        irq_b;

   int checks = 0;
   int errors = 0;

   pullup (bus_a);
   pullup (bus_b);
   assign bus_a = drive_a ? data_a : 32'bz;
   assign bus_b = drive_b ? data_b : 32'bz;

   configuration_register_bank #(
      .BASE_ADDRESS   (32'h0000_0100),
      .REGISTER_COUNT (2),
      .WIDTH          (32),
      .RESET_VALUE    (64'hA5A5_0001_0000_00FF),
      .STATUS_WIDTH   (8)
   ) dut_a (
      .clk              (clk),
      .rst              (rst),
      .we               (we_a),
      .oe               (oe_a),
      .interfaceAddress (addr_a),
      .byteSelect       (be_a),
      .interfaceData    (bus_a),
      .statusEvent      (event_a),
      .currentValues    (values_a),
      .registerWritten  (written_a),
      .statusValue      (status_a),
      .irq              (irq_a)
   );

   configuration_register_bank #(
      .BASE_ADDRESS   (32'h0000_0000),
      .REGISTER_COUNT (1),
      .WIDTH          (12),
      .RESET_VALUE    (12'h000),
      .STATUS_WIDTH   (0)
   ) dut_b (
      .clk              (clk),
      .rst              (rst),
      .we               (we_b),
      .oe               (oe_b),
      .interfaceAddress (addr_b),
      .byteSelect       (be_b),
      .interfaceData    (bus_b),
      .statusEvent      (1'b0),
      .currentValues    (values_b),
      .registerWritten  (written_b),
      .statusValue      (status_b),
      .irq              (irq_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Bank A write: one qualified write cycle, returns 1 time unit after the edge.
   task automatic write_a(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
      addr_a = addr; data_a = data; be_a = be;
      we_a = 1'b1; oe_a = 1'b0; drive_a = 1'b1;
      @(posedge clk); #1;
      we_a = 1'b0; drive_a = 1'b0;
   endtask

   // Bank A read: combinational, sampled within the current cycle.
   task automatic read_a(input logic [31:0] addr, output logic [31:0] data);
      addr_a = addr; we_a = 1'b0; oe_a = 1'b1; drive_a = 1'b0;
      #1;
      data = bus_a;
      oe_a = 1'b0;
   endtask

   task automatic idle_cycle;
      @(posedge clk); #1;
   endtask

   logic [31:0] rd;

   initial begin
      rst = 1'b1;
      we_a = 1'b0; oe_a = 1'b0; drive_a = 1'b0;
      addr_a = 32'h0; data_a = 32'h0; be_a = 4'h0; event_a = 8'h00;
      we_b = 1'b0; oe_b = 1'b0; drive_b = 1'b0;
      addr_b = 32'h0; data_b = 32'h0; be_b = 4'h0;

      idle_cycle();
      idle_cycle();
      check_value("reset_values",  values_a, 64'hA5A5_0001_0000_00FF);
      check_value("reset_strobe",  {62'd0, written_a}, 64'd0);
      check_value("reset_irq",     {63'd0, irq_a}, 64'd0);
      check_value("reset_status",  {56'd0, status_a}, 64'd0);
      rst = 1'b0;

      read_a(32'h0000_0100, rd);
      check_value("read_reset_r0", {32'd0, rd}, 64'h0000_0000_0000_00FF);
      read_a(32'h0000_0104, rd);
      check_value("read_reset_r1", {32'd0, rd}, 64'h0000_0000_A5A5_0001);

      // Full write then back-to-back partial write to register 1.
      write_a(32'h0000_0104, 32'hFFFF_FFFF, 4'b1111);
      check_value("strobe_first",  {62'd0, written_a}, 64'h2);
      write_a(32'h0000_0104, 32'h1234_5678, 4'b0101);
      check_value("strobe_b2b",    {62'd0, written_a}, 64'h2);
      check_value("partial_value", values_a, 64'hFF34_FF78_0000_00FF);
      idle_cycle();
      check_value("strobe_drop",   {62'd0, written_a}, 64'h0);
      read_a(32'h0000_0104, rd);
      check_value("read_partial",  {32'd0, rd}, 64'h0000_0000_FF34_FF78);

      // Zero byte enables: value unchanged, strobe still raised.
      write_a(32'h0000_0100, 32'hDEAD_BEEF, 4'b0000);
      check_value("be0_strobe",    {62'd0, written_a}, 64'h1);
      check_value("be0_value",     values_a, 64'hFF34_FF78_0000_00FF);

      // Status event sets bit 3 and irq.
      event_a = 8'h08;
      idle_cycle();
      event_a = 8'h00;
      check_value("event_irq",     {63'd0, irq_a}, 64'd1);
      read_a(32'h0000_0108, rd);
      check_value("status_read",   {32'd0, rd}, 64'h8);

      // W1C with byte 0 disabled does not clear.
      write_a(32'h0000_0108, 32'h0000_0008, 4'b1110);
      check_value("w1c_masked",    {56'd0, status_a}, 64'h8);
      // Writing 0 to bit 3 leaves it set.
      write_a(32'h0000_0108, 32'h0000_00F7, 4'b0001);
      check_value("w1c_zero_keep", {56'd0, status_a}, 64'h8);
      write_a(32'h0000_0108, 32'h0000_0008, 4'b1111);
      check_value("w1c_clear",     {56'd0, status_a}, 64'h0);
      check_value("w1c_irq",       {63'd0, irq_a}, 64'd0);
      check_value("status_no_strobe", {62'd0, written_a}, 64'h0);

      // Set wins over a same-cycle clear.
      event_a = 8'h08;
      write_a(32'h0000_0108, 32'h0000_0008, 4'b1111);
      event_a = 8'h00;
      check_value("set_wins",      {56'd0, status_a}, 64'h8);
      write_a(32'h0000_0108, 32'h0000_0008, 4'b1111);

      // we and oe together: no write, bus undriven (pulled high).
      addr_a = 32'h0000_0104; data_a = 32'h0000_0000; be_a = 4'b1111;
      we_a = 1'b1; oe_a = 1'b1; drive_a = 1'b0;
      #1;
      check_value("weoe_bus",      {32'd0, bus_a}, 64'h0000_0000_FFFF_FFFF);
      @(posedge clk); #1;
      we_a = 1'b0; oe_a = 1'b0;
      check_value("weoe_value",    values_a, 64'hFF34_FF78_0000_00FF);
      check_value("weoe_strobe",   {62'd0, written_a}, 64'h0);

      // Unmapped and misaligned reads leave the bus undriven.
      read_a(32'h0000_0140, rd);
      check_value("unmapped_read", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);
      read_a(32'h0000_0102, rd);
      check_value("misaligned_read", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);
      read_a(32'h0000_00FC, rd);
      check_value("below_base_read", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);

      // Reset during a write: write lost, no strobe.
      rst = 1'b1;
      write_a(32'h0000_0100, 32'h1357_9BDF, 4'b1111);
      rst = 1'b0;
      check_value("rst_write_value",  values_a, 64'hA5A5_0001_0000_00FF);
      check_value("rst_write_strobe", {62'd0, written_a}, 64'h0);

      // Narrow bank: upper bits discarded, read zero-extended, no status register.
      addr_b = 32'h0; data_b = 32'hFFFF_FABC; be_b = 4'b1111;
      we_b = 1'b1; drive_b = 1'b1;
      @(posedge clk); #1;
      we_b = 1'b0; drive_b = 1'b0;
      check_value("narrow_value",  {52'd0, values_b}, 64'hABC);
      check_value("narrow_strobe", {63'd0, written_b}, 64'h1);
      oe_b = 1'b1; #1;
      check_value("narrow_read",   {32'd0, bus_b}, 64'h0000_0000_0000_0ABC);
      addr_b = 32'h4; #1;
      check_value("narrow_no_status", {32'd0, bus_b}, 64'h0000_0000_FFFF_FFFF);
      oe_b = 1'b0;
      check_value("narrow_irq",    {63'd0, irq_b}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/configuration_register_bank.md
# configuration_register_bank

Parametrised bank of memory-mapped configuration registers with byte-enabled writes, per-register write strobes and a sticky write-1-to-clear status register with interrupt output. It replaces single-register instances on the peripheral configuration bus: one bank decodes a contiguous address window and drives the shared tri-state data bus on reads. Downstream logic consumes the register values and strobes, and upstream logic feeds status events.

## Interface
- `BASE_ADDRESS`, 32'h0: byte address of register 0; must be 4-byte aligned.
- `REGISTER_COUNT`, 4: number of configuration registers, 1..16.
- `WIDTH`, 32: bits per configuration register, 1..32.
- `RESET_VALUE`, 0: flat `REGISTER_COUNT*WIDTH` vector. Register i resets to bits `[i*WIDTH +: WIDTH]`.
- `STATUS_WIDTH`, 8: sticky status bits, 0..32. 0 removes the status register.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we` in 1: bus write request.
- `oe` in 1: bus read request.
- `interfaceAddress` in 32: byte address.
- `byteSelect` in 4: write byte enables; bit k covers data bits `[8k+7:8k]`.
- `interfaceData` inout 32: shared data bus.
- `statusEvent` in STATUS_WIDTH: per-bit event inputs, sampled every cycle.
- `currentValues` out `REGISTER_COUNT*WIDTH`: register i at `[i*WIDTH +: WIDTH]`.
- `registerWritten` out REGISTER_COUNT: one-cycle write strobe per register.
- `statusValue` out STATUS_WIDTH: current sticky status bits.
- `irq` out 1: OR of all status bits.

## Operation
- Decode:
  - Register i lives at `BASE_ADDRESS + 4*i`.
  - The status register lives at `BASE_ADDRESS + 4*REGISTER_COUNT`.
  - Every other address is unselected: no write and bus undriven.
- A write is `select && we && !oe`. A read is `select && oe && !we`. When `we` and `oe` are both high, neither happens and the bus stays at 'z.
- Config write: byte k of register i takes `interfaceData[8k+7:8k]` if `byteSelect[k]`. Bits at or above WIDTH are discarded. `byteSelect == 0` leaves the value unchanged but still raises the strobe.
- Status write: for each enabled byte, a data bit of 1 clears the matching status bit and a 0 leaves it. Status bits at or above STATUS_WIDTH ignore writes.
- Status set: `statusEvent[b]` high sets bit b, regardless of any write.
- Simultaneous set and clear on the same bit in the same cycle: set wins.
- Reads:
  - The selected register is zero-extended to 32 bits and driven onto `interfaceData`.
  - A status read returns the status bits zero-extended.
  - Unselected or invalid reads leave the bus at 32'bz.
- `irq = |statusValue`.

## Timing
- Reset values, at the first edge with `rst` high:
  - `currentValues = RESET_VALUE`
  - `registerWritten = 0`
  - status = 0
  - `irq = 0`
- `rst` wins over any same-cycle write or event. A write in progress during reset is lost.
- Write latency: a write qualified at edge N is visible on `currentValues` and on bus reads after edge N.
- `registerWritten[i]` is registered. It is high for exactly the cycle after edge N, and high on consecutive cycles for back-to-back writes.
- Status set latency: an event sampled at edge N makes the bit and `irq` visible after edge N. `irq` is combinational from the status flops and adds no extra cycle.
- Read path is combinational from address, `oe`, `we` and register state, with zero-cycle latency. A read in the same cycle as a write to the same register returns the old value.

## Structure
- Shared include file `configuration_bus_defs.vh` holds:
  - `REGISTER_STRIDE = 4`
  - `BUS_WIDTH = 32`
  - `BYTE_COUNT = 4`
- One sub-module, `configuration_register_cell`, is instantiated REGISTER_COUNT times via generate. It contains WIDTH flops with a per-byte write mask, a reset value, and the registered write strobe.
- The status logic, address decode and tri-state read mux live in the top module.
- Only the top module drives `interfaceData`, through a single tri-state assign.

## Test plan
- Reset with `RESET_VALUE = {32'hA5A5_0001, 32'h0000_00FF}`, `REGISTER_COUNT = 2` -> both slices match; `registerWritten = 0`; `irq = 0`; bus reads return the reset values.
- Write 32'h1234_5678 to register 1 with `byteSelect = 4'b0101` over old value 32'hFFFF_FFFF -> reads 32'hFF34_FF78; `registerWritten = 2'b10` for exactly one cycle.
- `WIDTH = 12`: write 32'hFFFF_FABC -> reads 32'h0000_0ABC.
- Pulse `statusEvent[3]` for one cycle -> status reads 32'h8; `irq = 1`. Write 32'h8 to the status address -> status 0 and `irq = 0` next cycle.
- Same cycle: `statusEvent[3]` high and a W1C of bit 3 -> bit stays 1.
- `we` and `oe` both high at a valid address -> no register change, bus stays 'z. A read at an unmapped address (`BASE_ADDRESS + 0x40`) -> bus 'z.
- Assert `rst` during a write cycle -> register returns to its reset value and no strobe fires.
